ch376_bus_arbiter: RTL

Clocked arbiter and bus sequencer for the CH376S USB host controller's 8-bit parallel port. It sits between two requesters and the CH376 pins. The first requester is the Z80 I/O path, with command port 0x11/0x21 mapped to a0=1 and data port 0x10/0x20 mapped to a0=0. The second is an internal sector-transfer engine. The block grants one requester at a time and generates CS#/A0/RD#/WR# strobes with programmable setup, strobe, hold and post-command gap times. It also keeps multi-byte engine sequences atomic.

---
 rtl/ch376_bus_arbiter_if.sv | 41 ++++
 rtl/ch376_bus_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ch376_bus_arbiter_if.sv
// Requester and CH376 pin bundle for ch376_bus_arbiter.
// Handshake: a requester raises req (level, with wr/a0/wdata stable) and keeps it high until the one-cycle ack pulse; ack is the only completion signal.
interface ch376_bus_arbiter_if;
  logic       host_req;
  logic       host_wr;
  logic       host_a0;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       eng_req;
  logic       eng_wr;
  logic       eng_a0;
  logic [7:0] eng_wdata;
  logic       eng_lock;
  logic       eng_ack;
  logic [7:0] eng_rdata;
  logic       ch_cs_n;
  logic       ch_rd_n;
  logic       ch_wr_n;
  logic       ch_a0;
  logic [7:0] ch_dout;
  logic       ch_doe;
  logic [7:0] ch_din;
  logic       busy;

  modport slave (
    input  host_req, host_wr, host_a0, host_wdata,
    input  eng_req, eng_wr, eng_a0, eng_wdata, eng_lock,
    input  ch_din,
    output host_ack, host_rdata, eng_ack, eng_rdata,
    output ch_cs_n, ch_rd_n, ch_wr_n, ch_a0, ch_dout, ch_doe, busy
  );

  modport master (
    output host_req, host_wr, host_a0, host_wdata,
    output eng_req, eng_wr, eng_a0, eng_wdata, eng_lock,
    output ch_din,
    input  host_ack, host_rdata, eng_ack, eng_rdata,
    input  ch_cs_n, ch_rd_n, ch_wr_n, ch_a0, ch_dout, ch_doe, busy
  );
endinterface

// File: rtl/ch376_bus_arbiter.sv
// Two-requester arbiter and strobe sequencer for the CH376 8-bit parallel port.
// Optional macro CH376_ARB_RR_EN selects round-robin instead of fixed host priority.
module ch376_bus_arbiter #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 3,
  parameter int HOLD_CYC    = 1,
  parameter int CMD_GAP_CYC = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  ch376_bus_arbiter_if.slave        bus,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic       wr_q, wr_d;
  logic       a0_q, a0_d;
  logic [7:0] dout_q, dout_d;
  logic       mask_q, mask_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       doe_q, doe_d;
  logic       host_ack_q, host_ack_d;
  logic       eng_ack_q, eng_ack_d;
  logic [7:0] host_rdata_q, host_rdata_d;
  logic [7:0] eng_rdata_q, eng_rdata_d;
`ifdef CH376_ARB_RR_EN
  logic       last_q, last_d;
`endif

  logic host_ok;
  logic grant_eng;
  logic finish;
  logic in_win;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    wr_d         = wr_q;
    a0_d         = a0_q;
    dout_d       = dout_q;
    mask_d       = mask_q && bus.eng_lock;
    host_rdata_d = host_rdata_q;
    eng_rdata_d  = eng_rdata_q;
    host_ack_d   = 1'b0;
    eng_ack_d    = 1'b0;
    grant_eng    = 1'b0;
    finish       = 1'b0;
`ifdef CH376_ARB_RR_EN
    last_d       = last_q;
`endif
    // The lock mask only bites while eng_lock is still asserted.
    host_ok = bus.host_req && !(mask_q && bus.eng_lock);

    case (state_q)
      S_IDLE: begin
        if (!host_ack_q && !eng_ack_q && (host_ok || bus.eng_req)) begin
`ifdef CH376_ARB_RR_EN
          grant_eng = bus.eng_req && (!host_ok || !last_q);
          last_d    = grant_eng;
`else
          grant_eng = !host_ok;
`endif
          sel_d  = grant_eng;
          wr_d   = grant_eng ? bus.eng_wr    : bus.host_wr;
          a0_d   = grant_eng ? bus.eng_a0    : bus.host_a0;
          dout_d = grant_eng ? bus.eng_wdata : bus.host_wdata;
          if (grant_eng) mask_d = bus.eng_lock;
          if (SETUP_CYC > 0) begin
            state_d = S_SETUP;
            cnt_d   = 4'(SETUP_CYC - 1);
          end else begin
            state_d = S_STROBE;
            cnt_d   = 4'(STROBE_CYC - 1);
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = 4'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) begin
            if (sel_q) eng_rdata_d  = bus.ch_din;
            else       host_rdata_d = bus.ch_din;
          end
          if (HOLD_CYC > 0) begin
            state_d = S_HOLD;
            cnt_d   = 4'(HOLD_CYC - 1);
          end else begin
            finish = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) finish = 1'b1;
        else               cnt_d  = cnt_q - 4'd1;
      end
      S_GAP: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      host_ack_d = !sel_q;
      eng_ack_d  = sel_q;
      if (wr_q && a0_q && (CMD_GAP_CYC > 0)) begin
        state_d = S_GAP;
        cnt_d   = 4'(CMD_GAP_CYC - 1);
      end else begin
        state_d = S_IDLE;
      end
    end

    // Pin outputs are decoded from the next state so they are registered.
    in_win = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    cs_n_d = !in_win;
    rd_n_d = !((state_d == S_STROBE) && !wr_d);
    wr_n_d = !((state_d == S_STROBE) && wr_d);
    doe_d  = in_win && wr_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      sel_q        <= 1'b0;
      wr_q         <= 1'b0;
      a0_q         <= 1'b0;
      dout_q       <= 8'h00;
      mask_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      doe_q        <= 1'b0;
      host_ack_q   <= 1'b0;
      eng_ack_q    <= 1'b0;
      host_rdata_q <= 8'h00;
      eng_rdata_q  <= 8'h00;
`ifdef CH376_ARB_RR_EN
      last_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      wr_q         <= wr_d;
      a0_q         <= a0_d;
      dout_q       <= dout_d;
      mask_q       <= mask_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      doe_q        <= doe_d;
      host_ack_q   <= host_ack_d;
      eng_ack_q    <= eng_ack_d;
      host_rdata_q <= host_rdata_d;
      eng_rdata_q  <= eng_rdata_d;
`ifdef CH376_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign bus.ch_cs_n    = cs_n_q;
  assign bus.ch_rd_n    = rd_n_q;
  assign bus.ch_wr_n    = wr_n_q;
  assign bus.ch_a0      = a0_q;
  assign bus.ch_dout    = dout_q;
  assign bus.ch_doe     = doe_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.eng_ack    = eng_ack_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.eng_rdata  = eng_rdata_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign dbg_state      = state_q;

endmodule
